// File: rtl/arb_pkg.sv
// Shared definitions for the SRAM arbiter: response-owner encoding and
// default bus widths.
package arb_pkg;

  // Response owner: who receives the SRAM read data next cycle
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_IF   = 2'd1;
  localparam logic [1:0] OWN_MEM  = 2'd2;

  localparam int ARB_ADDR_W = 32;
  localparam int ARB_DATA_W = 32;

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating starvation counter. Counts fetch losses and flags when the
// fetch port has lost STARVE_LIMIT times in a row.
module arb_starve_cnt #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_at_limit
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] r_cnt;

  // Clear has priority; increment stops at the limit
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != LIMIT)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_at_limit = (r_cnt == LIMIT);

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates one single-port synchronous SRAM between the instruction
// fetch port (IF) and the data port (MEM), and steers the 1-cycle-latency
// read data back to whichever port issued the read.
//
// resp_owner FSM
//   state    | meaning
//   OWN_NONE | no read issued last cycle; ram_rdata is not meaningful
//   OWN_IF   | last cycle's read belongs to IF; if_rvalid this cycle
//   OWN_MEM  | last cycle's read belongs to MEM; mem_rvalid this cycle
module sram_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W       = ARB_ADDR_W,
  parameter int DATA_W       = ARB_DATA_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  // fetch port
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              is_if_read,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_rvalid,
  // data port
  input  logic              mem_req,
  input  logic [3:0]        mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_grant,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_rvalid,
  // SRAM side
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  logic              w_at_limit;
  logic              w_if_win;
  logic              w_mem_win;
  logic              w_starve_inc;
  logic              w_starve_clr;
  logic [1:0]        r_resp_owner;
  logic [1:0]        w_resp_next;
  logic [DATA_W-1:0] r_if_hold;
  logic [DATA_W-1:0] r_mem_hold;

  // MEM normally wins; a starved IF takes exactly one cycle back
  assign w_if_win   = if_req && (!mem_req || w_at_limit);
  assign w_mem_win  = mem_req && !w_if_win;
  assign is_if_read = !reset && w_if_win;
  assign mem_grant  = !reset && w_mem_win;

  assign w_starve_inc = if_req && mem_grant;
  assign w_starve_clr = !if_req || is_if_read;

  arb_starve_cnt #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve_cnt (
    .clk       (clk),
    .reset     (reset),
    .i_inc     (w_starve_inc),
    .i_clr     (w_starve_clr),
    .o_at_limit(w_at_limit)
  );

  // SRAM request mux: only the winner reaches the RAM, writes only from MEM
  always_comb begin
    ram_en    = is_if_read || mem_grant;
    ram_we    = 4'b0000;
    ram_addr  = '0;
    ram_wdata = '0;
    if (mem_grant) begin
      ram_we    = mem_we;
      ram_addr  = mem_addr;
      ram_wdata = mem_wdata;
    end else if (is_if_read) begin
      ram_addr  = if_addr;
    end
  end

  // Next response owner: reads produce a response, writes do not
  always_comb begin
    w_resp_next = OWN_NONE;
    if (is_if_read) begin
      w_resp_next = OWN_IF;
    end else if (mem_grant && (mem_we == 4'b0000)) begin
      w_resp_next = OWN_MEM;
    end
  end

  // Response owner register; reset drops any read in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      r_resp_owner <= OWN_NONE;
    end else begin
      r_resp_owner <= w_resp_next;
    end
  end

  assign if_rvalid  = !reset && (r_resp_owner == OWN_IF);
  assign mem_rvalid = !reset && (r_resp_owner == OWN_MEM);

  // Capture returned data per port so a stalled consumer sees stable data
  always_ff @(posedge clk) begin
    if (reset) begin
      r_if_hold  <= '0;
      r_mem_hold <= '0;
    end else begin
      if (if_rvalid) begin
        r_if_hold <= ram_rdata;
      end
      if (mem_rvalid) begin
        r_mem_hold <= ram_rdata;
      end
    end
  end

  assign if_rdata  = if_rvalid  ? ram_rdata : r_if_hold;
  assign mem_rdata = mem_rvalid ? ram_rdata : r_mem_hold;

endmodule
